// File: rtl/line_cond_pkg.sv
// ============================================================================
// line_cond_pkg : shared mode encodings and helpers for the line conditioner
// Revision      : 1.0
// ============================================================================
`default_nettype none

package line_cond_pkg;

  localparam int         MODE_W        = 2;
  localparam logic [1:0] MODE_PASS     = 2'd0;
  localparam logic [1:0] MODE_DEBOUNCE = 2'd1;
  localparam logic [1:0] MODE_RISE     = 2'd2;
  localparam logic [1:0] MODE_FALL     = 2'd3;

  // Select width stays at least one bit so a single-line build still has a port.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_cond_cell.sv
// ============================================================================
// line_cond_cell : one conditioned line - synchroniser, invert, mode logic
// Revision       : 1.0
// ============================================================================
`default_nettype none

module line_cond_cell
  import line_cond_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              line_in,
  output logic              line_out,
  input  logic              cfg_wr,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic              cfg_invert,
  input  logic [LEN_W-1:0]  cfg_len
);

  logic              s1_q, s2_q;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              inv_q, inv_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              stable_q, stable_d;
  logic              stable_dly_q, stable_dly_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  str_q, str_d;
  logic              out_q, out_d;

  logic v;
  logic evt;

  assign v   = s2_q ^ inv_q;
  assign evt = (mode_q == MODE_RISE) ? (stable_q & ~stable_dly_q)
                                     : (~stable_q & stable_dly_q);

  always_comb begin
    mode_d       = mode_q;
    inv_d        = inv_q;
    len_d        = len_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    cnt_d        = cnt_q;
    str_d        = str_q;
    out_d        = out_q;

    if (cfg_wr) begin
      // Edge history is reloaded from the new v so a mode/invert change cannot fake an event.
      mode_d       = cfg_mode;
      inv_d        = cfg_invert;
      len_d        = cfg_len;
      cnt_d        = '0;
      str_d        = '0;
      out_d        = 1'b0;
      stable_d     = s2_q ^ cfg_invert;
      stable_dly_d = s2_q ^ cfg_invert;
    end else begin
      case (mode_q)
        MODE_PASS: begin
          out_d    = v;
          stable_d = v;
          cnt_d    = '0;
          str_d    = '0;
        end
        MODE_DEBOUNCE: begin
          out_d = stable_q;
          if (v != stable_q) begin
            if (cnt_q == len_q) begin
              stable_d = v;
              cnt_d    = '0;
            end else if (cnt_q != '1) begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          stable_d = v;
          if (evt) begin
            out_d = 1'b1;
            str_d = len_q;
          end else if (str_q != '0) begin
            out_d = 1'b1;
            str_d = str_q - LEN_W'(1);
          end else begin
            out_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      mode_q       <= MODE_PASS;
      inv_q        <= 1'b0;
      len_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      str_q        <= '0;
      out_q        <= 1'b0;
    end else begin
      s1_q         <= line_in;
      s2_q         <= s1_q;
      mode_q       <= mode_d;
      inv_q        <= inv_d;
      len_q        <= len_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      str_q        <= str_d;
      out_q        <= out_d;
    end
  end

  assign line_out = out_q;

endmodule

`default_nettype wire

// File: rtl/line_conditioner.sv
// ============================================================================
// line_conditioner : bank of independent per-line conditioning cells
// Revision         : 1.0
// ============================================================================
`default_nettype none

module line_conditioner
  import line_cond_pkg::*;
#(
  parameter int NUM_LINES = 10,
  parameter int LEN_W     = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_LINES-1:0]        lines_in,
  output logic [NUM_LINES-1:0]        lines_out,
  input  logic                        cfg_wr,
  input  logic [sel_w(NUM_LINES)-1:0] cfg_sel,
  input  logic [MODE_W-1:0]           cfg_mode,
  input  logic                        cfg_invert,
  input  logic [LEN_W-1:0]            cfg_len
);

  localparam int SEL_W = sel_w(NUM_LINES);

  // Out-of-range selects match no cell, so such writes are dropped naturally.
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_cell
    logic wr_hit;
    assign wr_hit = cfg_wr && (cfg_sel == SEL_W'(i));

    line_cond_cell #(
      .LEN_W (LEN_W)
    ) u_cell (
      .clk        (clk),
      .rstn       (rstn),
      .line_in    (lines_in[i]),
      .line_out   (lines_out[i]),
      .cfg_wr     (wr_hit),
      .cfg_mode   (cfg_mode),
      .cfg_invert (cfg_invert),
      .cfg_len    (cfg_len)
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_line_conditioner.sv
// ============================================================================
// tb_line_conditioner : directed + random bench with a behavioural line model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_line_conditioner;
  import line_cond_pkg::*;

  localparam int N     = 10;
  localparam int LEN_W = 16;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     lines_in;
  logic [N-1:0]     lines_out;
  logic             cfg_wr;
  logic [SEL_W-1:0] cfg_sel;
  logic [1:0]       cfg_mode;
  logic             cfg_invert;
  logic [LEN_W-1:0] cfg_len;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  line_conditioner #(.NUM_LINES(N), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .lines_in   (lines_in),
    .lines_out  (lines_out),
    .cfg_wr     (cfg_wr),
    .cfg_sel    (cfg_sel),
    .cfg_mode   (cfg_mode),
    .cfg_invert (cfg_invert),
    .cfg_len    (cfg_len)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: 2-edge delay line, run-length debounce, and a pulse
  // that is high while fewer than len+1 edges have passed since the last event.
  bit         m_s1[N], m_s2[N], m_inv[N], m_stable[N], m_prev[N];
  int         m_mode[N], m_len[N], m_run[N];
  longint     m_last[N];
  longint     now = 0;
  logic [N-1:0] m_out;

  always @(posedge clk) begin
    bit v, evt;
    now++;
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_inv[i] = 0; m_stable[i] = 0; m_prev[i] = 0;
        m_mode[i] = 0; m_len[i] = 0; m_run[i] = 0; m_last[i] = -(64'sd1 << 40);
      end
      m_out = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        v = m_s2[i] ^ m_inv[i];
        if (cfg_wr && int'(cfg_sel) == i) begin
          m_mode[i]   = int'(cfg_mode);
          m_inv[i]    = cfg_invert;
          m_len[i]    = int'(cfg_len);
          m_run[i]    = 0;
          m_out[i]    = 1'b0;
          m_stable[i] = m_s2[i] ^ cfg_invert;
          m_prev[i]   = m_stable[i];
          m_last[i]   = -(64'sd1 << 40);
        end else if (m_mode[i] == 0) begin
          m_out[i] = v;
        end else if (m_mode[i] == 1) begin
          m_out[i] = m_stable[i];
          if (v != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == m_len[i] + 1) begin
              m_stable[i] = v;
              m_run[i]    = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end else begin
          evt = (m_mode[i] == 2) ? (m_stable[i] && !m_prev[i]) : (!m_stable[i] && m_prev[i]);
          m_prev[i]   = m_stable[i];
          m_stable[i] = v;
          if (evt) m_last[i] = now;
          m_out[i] = ((now - m_last[i]) <= longint'(m_len[i]));
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = lines_in[i];
      end
    end
  end

  always @(negedge clk) if (chk_en) check("lines_out_vs_model", 32'(lines_out), 32'(m_out));

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_cfg(input int sel, input logic [1:0] mode, input bit inv, input int len);
    cfg_sel    = sel[SEL_W-1:0];
    cfg_mode   = mode;
    cfg_invert = inv;
    cfg_len    = len[LEN_W-1:0];
    cfg_wr     = 1'b1;
    @(negedge clk);
    cfg_wr     = 1'b0;
  endtask

  initial begin
    int rise, fall, hi, first, last, idx;
    logic [N-1:0] snap;
    rstn = 0; lines_in = '0; cfg_wr = 0; cfg_sel = '0; cfg_mode = '0; cfg_invert = 0; cfg_len = '0;
    cyc(3);
    check("reset_out", 32'(lines_out), 32'h0);
    chk_en = 1;
    rstn   = 1;

    // PASS latency on line 3
    lines_in[3] = 1'b1;
    cyc(1); check("pass_k",   32'(lines_out[3]), 32'h0);
    cyc(1); check("pass_k1",  32'(lines_out[3]), 32'h0);
    cyc(1); check("pass_k2",  32'(lines_out), 32'h008);

    // DEBOUNCE len=4: short glitch rejected, long pulse delayed by len+3
    wr_cfg(0, MODE_DEBOUNCE, 0, 4);
    lines_in[0] = 1'b1; cyc(3); lines_in[0] = 1'b0;
    hi = 0;
    for (int j = 0; j < 12; j++) begin @(negedge clk); hi += int'(lines_out[0]); end
    check("deb_glitch_hi", 32'(hi), 32'd0);
    lines_in[0] = 1'b1; rise = -1; fall = -1;
    for (int j = 0; j < 26; j++) begin
      @(negedge clk);
      if (lines_out[0] && rise < 0) rise = j;
      if (!lines_out[0] && rise >= 0 && fall < 0) fall = j;
      if (j == 9) lines_in[0] = 1'b0;
    end
    check("deb_rise_edge", 32'(rise), 32'd7);
    check("deb_fall_edge", 32'(fall), 32'd17);

    // RISE len=2 on line 5, two steps
    wr_cfg(5, MODE_RISE, 0, 2);
    lines_in[5] = 1'b1; rise = -1; hi = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (lines_out[5] && rise < 0) rise = j;
      hi += int'(lines_out[5]);
      if (j == 4) lines_in[5] = 1'b0;
      if (j == 6) lines_in[5] = 1'b1;
    end
    check("rise_first_edge", 32'(rise), 32'd3);
    check("rise_hi_cycles",  32'(hi),   32'd6);

    // FALL len=0 with invert on line 1
    wr_cfg(1, MODE_FALL, 1, 0);
    lines_in[1] = 1'b1; hi = 0;
    for (int j = 0; j < 10; j++) begin @(negedge clk); hi += int'(lines_out[1]); end
    check("fall_inv_hi", 32'(hi), 32'd1);

    // Retrigger: RISE len=5 on line 2, re-pulsed mid-pulse
    wr_cfg(2, MODE_RISE, 0, 5);
    lines_in[2] = 1'b1; hi = 0; first = -1; last = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (lines_out[2]) begin
        hi++; last = j;
        if (first < 0) first = j;
      end
      if (j == 0) lines_in[2] = 1'b0;
      if (j == 2) lines_in[2] = 1'b1;
    end
    check("retrig_first", 32'(first), 32'd3);
    check("retrig_hi",    32'(hi),    32'd9);
    check("retrig_nogap", 32'(last - first + 1), 32'(hi));

    // Invalid select leaves everything alone
    cyc(3);
    snap = lines_out;
    wr_cfg(N, MODE_FALL, 1, 3);
    cyc(3);
    check("bad_sel_nochange", 32'(lines_out), 32'(snap));

    // Invert toggle on a high PASS line, then switch to RISE without an event
    lines_in[7] = 1'b1; cyc(4);
    check("inv_pre_high", 32'(lines_out[7]), 32'h1);
    wr_cfg(7, MODE_PASS, 1, 0);
    check("inv_after_wr", 32'(lines_out[7]), 32'h0);
    cyc(1); check("inv_follow_low", 32'(lines_out[7]), 32'h0);
    lines_in[7] = 1'b0; cyc(3);
    check("inv_follow_high", 32'(lines_out[7]), 32'h1);
    lines_in[7] = 1'b1; cyc(3);
    wr_cfg(7, MODE_RISE, 0, 3);
    hi = 0;
    for (int j = 0; j < 8; j++) begin @(negedge clk); hi += int'(lines_out[7]); end
    check("rise_switch_noevt", 32'(hi), 32'd0);

    // Reset mid-pulse (line 2) and mid-debounce (line 0)
    lines_in[2] = 1'b0; cyc(3);
    lines_in[2] = 1'b1; lines_in[0] = 1'b1; cyc(4);
    check("pre_rst_pulse", 32'(lines_out[2]), 32'h1);
    rstn = 0; cyc(1);
    check("rst_mid_out", 32'(lines_out), 32'h0);
    rstn = 1;
    lines_in = '1; cyc(3);
    check("post_rst_pass_hi", 32'(lines_out), 32'h3FF);
    lines_in = '0; cyc(3);
    check("post_rst_pass_lo", 32'(lines_out), 32'h0);

    // Random traffic against the model
    for (int j = 0; j < 600; j++) begin
      if (cfg_wr) cfg_wr = 1'b0;
      else if ($urandom_range(0, 11) == 0) begin
        cfg_sel    = SEL_W'($urandom_range(0, 15));
        cfg_mode   = 2'($urandom_range(0, 3));
        cfg_invert = 1'($urandom_range(0, 1));
        cfg_len    = LEN_W'($urandom_range(0, 6));
        cfg_wr     = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, N - 1);
        lines_in[idx] = ~lines_in[idx];
      end
      @(negedge clk);
    end
    cfg_wr = 1'b0;
    cyc(2);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
